// File: rtl/spi_pkg.sv
// Shared types and constants for the multi-slave SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int MIN_DATA_W = 2;

endpackage

// File: rtl/spi_master_multi_if.sv
// Control-register side and pin side of the SPI master, bundled as one interface.
interface spi_master_multi_if #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 2,
  parameter int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1,
  parameter int DIV_W  = 8
);
  logic              start;
  logic [SEL_W-1:0]  ss_sel;
  logic              cpol;
  logic              cpha;
  logic [DIV_W-1:0]  clk_div;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              done;
  logic              err;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [NUM_SS-1:0] ss_n;

  modport master (
    input  start, ss_sel, cpol, cpha, clk_div, tx_data, miso,
    output rx_data, busy, done, err, sclk, mosi, ss_n
  );

  modport slave (
    output start, ss_sel, cpol, cpha, clk_div, tx_data, miso,
    input  rx_data, busy, done, err, sclk, mosi, ss_n
  );
endinterface

// File: rtl/spi_half_period_tick.sv
// Half-period timer: after load, emits a one-cycle tick every div+1 enabled cycles.
module spi_half_period_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == div);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end
endmodule

// File: rtl/spi_master_multi.sv
// Full-duplex MSB-first SPI master with N slave selects, four SPI modes and a runtime divider.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 2,
  parameter int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1,
  parameter int DIV_W  = 8
) (
  input logic                clk,
  input logic                reset_n,
  spi_master_multi_if.master bus
);
  localparam int EDGES = 2 * DATA_W;
  localparam int EC_W  = $clog2(EDGES + 1);

  if (DATA_W < MIN_DATA_W) begin : g_bad_data_w
    $error("spi_master_multi: DATA_W below minimum");
  end

  spi_state_t        state, state_nxt;
  logic              accept, bad_sel, do_edge, finish, tick, tick_en;
  logic [SEL_W-1:0]  sel;
  logic [1:0]        mode_q;
  logic [DIV_W-1:0]  div_q;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic [EC_W-1:0]   edge_cnt, edge_k;
  logic              odd_edge, last_edge, sample, drive, shift_tx;

  assign sel       = bus.ss_sel;
  assign tick_en   = (state != IDLE);
  assign edge_k    = edge_cnt + EC_W'(1);
  assign odd_edge  = edge_k[0];
  assign last_edge = (edge_k == EC_W'(EDGES));
  // cpha=0 samples leading edges; cpha=1 drives on leading edges (edge 1 re-drives the MSB)
  assign sample    = (mode_q == MODE0 || mode_q == MODE2) ? odd_edge : ~odd_edge;
  assign drive     = (mode_q == MODE1 || mode_q == MODE3) ? odd_edge : (~odd_edge & ~last_edge);
  assign shift_tx  = drive && (edge_k != EC_W'(1));

  spi_half_period_tick #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .en      (tick_en),
    .div     (div_q),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    bad_sel   = 1'b0;
    do_edge   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (int'(sel) >= NUM_SS) begin
            bad_sel = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = SETUP;
          end
        end
      end
      SETUP: begin
        if (tick) begin
          do_edge   = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (tick) begin
          do_edge = 1'b1;
          if (last_edge) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (tick) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- registered pin and status outputs ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.sclk    <= 1'b0;
      bus.mosi    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
      bus.rx_data <= '0;
      bus.ss_n    <= '1;
      edge_cnt    <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      if (state == IDLE) bus.sclk <= bus.cpol;
      if (bad_sel) begin
        bus.done <= 1'b1;
        bus.err  <= 1'b1;
      end
      if (accept) begin
        bus.busy <= 1'b1;
        bus.ss_n <= ~(NUM_SS'(1) << sel);
        bus.mosi <= bus.tx_data[DATA_W-1];
        edge_cnt <= '0;
      end
      if (do_edge) begin
        bus.sclk <= ~bus.sclk;
        edge_cnt <= edge_k;
        if (drive) bus.mosi <= shift_tx ? tx_sh[DATA_W-2] : tx_sh[DATA_W-1];
      end
      if (finish) begin
        bus.ss_n    <= '1;
        bus.busy    <= 1'b0;
        bus.done    <= 1'b1;
        bus.rx_data <= rx_sh;
      end
    end
  end

  // ---- transfer configuration and shift registers ----
  always_ff @(posedge clk) begin
    if (accept) begin
      mode_q <= {bus.cpol, bus.cpha};
      div_q  <= bus.clk_div;
      tx_sh  <= bus.tx_data;
    end else if (do_edge) begin
      if (shift_tx) tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
      if (sample)   rx_sh <= {rx_sh[DATA_W-2:0], bus.miso};
    end
  end
endmodule

// File: tb/tb_spi_master_multi.sv
// Scoreboard bench for spi_master_multi with a behavioural SPI slave and per-cycle pin expectations.
`timescale 1ns/1ps
module tb_spi_master_multi;
  localparam int DATA_W = 8;
  localparam int NUM_SS = 3;
  localparam int SEL_W  = 2;
  localparam int DIV_W  = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_multi_if #(.DATA_W(DATA_W), .NUM_SS(NUM_SS), .SEL_W(SEL_W), .DIV_W(DIV_W)) bus ();

  spi_master_multi #(.DATA_W(DATA_W), .NUM_SS(NUM_SS), .SEL_W(SEL_W), .DIV_W(DIV_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] rx;
    logic       err;
    int         cyc;
    logic       chk_slv;
    logic [7:0] slv;
  } sb_t;

  typedef struct packed {
    logic [2:0] ss;
    logic       sclk;
    logic       busy;
  } ce_t;

  sb_t  sb[$];
  ce_t  ce[int];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_count = 0;
  int   last_T = 0;
  int   last_L = 0;
  logic [7:0] model_rx = 8'h00;

  logic       loopback = 1'b1;
  logic       slv_miso = 1'b0;
  logic [7:0] slv_tx = 8'h00;
  logic [7:0] slv_rx = 8'h00;
  int         slv_edges = 0;
  int         cur_sel = 0;
  bit         cur_cpha = 1'b0;

  assign bus.miso = loopback ? bus.mosi : slv_miso;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural slave: reacts to visible sclk/ss_n changes just after each clock edge.
  initial begin
    logic [2:0] prev_ss;
    logic       prev_sclk;
    prev_ss = 3'b111;
    prev_sclk = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_ss[cur_sel] && !bus.ss_n[cur_sel]) begin
        slv_edges = 0;
        slv_rx = 8'h00;
        if (!cur_cpha) slv_miso = slv_tx[7];
      end else if (!bus.ss_n[cur_sel] && bus.sclk !== prev_sclk) begin
        slv_edges++;
        if (cur_cpha ? (slv_edges % 2 == 0) : (slv_edges % 2 == 1))
          slv_rx = {slv_rx[6:0], bus.mosi};
        else if (cur_cpha)
          slv_miso = slv_tx[7 - (slv_edges - 1) / 2];
        else if (slv_edges < 2 * DATA_W)
          slv_miso = slv_tx[7 - slv_edges / 2];
      end
      prev_ss = bus.ss_n;
      prev_sclk = bus.sclk;
    end
  end

  // Monitor: per-cycle pin expectations and scoreboard pop on each done pulse.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (ce.exists(cyc)) begin
        chk("ss_n", 32'(bus.ss_n), 32'(ce[cyc].ss));
        chk("sclk", 32'(bus.sclk), 32'(ce[cyc].sclk));
        chk("busy", 32'(bus.busy), 32'(ce[cyc].busy));
      end
      if (reset_n && bus.done) begin
        done_count++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("rx_data", 32'(bus.rx_data), 32'(e.rx));
          chk("err", 32'(bus.err), 32'(e.err));
          if (e.chk_slv) chk("slave_rx", 32'(slv_rx), 32'(e.slv));
        end
      end else if (reset_n && bus.err) begin
        chk("err_without_done", 32'(bus.err), 32'd0);
      end
    end
  end

  // Call at a negedge+1; issues a start for one cycle and records what should follow.
  task automatic issue(input int sel, input bit pol, input bit pha, input int div,
                       input logic [7:0] tx, input bit loop, input logic [7:0] sw);
    sb_t e;
    int  T, H, L, ed;
    T = cyc;
    H = div + 1;
    bus.ss_sel  = SEL_W'(sel);
    bus.cpol    = pol;
    bus.cpha    = pha;
    bus.clk_div = DIV_W'(div);
    bus.tx_data = tx;
    bus.start   = 1'b1;
    if (sel >= NUM_SS) begin
      e.rx = model_rx; e.err = 1'b1; e.cyc = T + 1; e.chk_slv = 1'b0; e.slv = 8'h00;
      for (int k = 1; k <= 4; k++) ce[T + k] = '{ss: 3'b111, sclk: pol, busy: 1'b0};
      L = 1;
    end else begin
      loopback = loop;
      cur_sel  = sel;
      cur_cpha = pha;
      slv_tx   = sw;
      L = 1 + (2 * DATA_W + 1) * H;
      e.rx = loop ? tx : sw; e.err = 1'b0; e.cyc = T + L; e.chk_slv = !loop; e.slv = tx;
      model_rx = e.rx;
      for (int c = T + 1; c < T + L; c++) begin
        ed = (c - T - 1) / H;
        if (ed > 2 * DATA_W) ed = 2 * DATA_W;
        ce[c] = '{ss: ~(3'b001 << sel), sclk: pol ^ ed[0], busy: 1'b1};
      end
      ce[T + L] = '{ss: 3'b111, sclk: pol, busy: 1'b0};
    end
    sb.push_back(e);
    last_T = T;
    last_L = L;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    do begin @(negedge clk); #1; end while (cyc < c);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (sb.size() != 0 && n < 6000);
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dc;
    bus.start = 1'b0; bus.ss_sel = '0; bus.cpol = 1'b0; bus.cpha = 1'b0;
    bus.clk_div = '0; bus.tx_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ss_n", 32'(bus.ss_n), 32'h7);
    chk("rst_sclk", 32'(bus.sclk), 32'd0);
    chk("rst_mosi", 32'(bus.mosi), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_rx", 32'(bus.rx_data), 32'd0);
    reset_n = 1'b1;
    repeat (2) begin @(negedge clk); #1; end

    // mode 0, H=1, loopback
    issue(0, 0, 0, 0, 8'hA5, 1, 8'h00);
    wait_idle();
    repeat (2) begin @(negedge clk); #1; end

    // mode 3, H=4, slave returns 0x96
    issue(0, 1, 1, 3, 8'h3C, 0, 8'h96);
    wait_idle();
    repeat (2) begin @(negedge clk); #1; end

    // start while busy is ignored, along with changed inputs
    issue(1, 0, 0, 0, 8'h3C, 1, 8'h00);
    wait_until(last_T + 5);
    bus.start = 1'b1; bus.tx_data = 8'h00; bus.ss_sel = 2'd2;
    @(posedge clk);
    #1 bus.start = 1'b0;
    dc = done_count;
    wait_idle();
    chk("single_done", done_count, dc + 1);
    repeat (2) begin @(negedge clk); #1; end

    // invalid slave select
    issue(3, 0, 0, 0, 8'h11, 1, 8'h00);
    wait_idle();
    repeat (4) begin @(negedge clk); #1; end

    // reset after edge 7 of a mode 1 transfer
    issue(0, 0, 1, 1, 8'h5A, 1, 8'h00);
    wait_until(last_T + 1 + 7 * 2);
    chk("pre_abort_busy", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_ss_n", 32'(bus.ss_n), 32'h7);
    chk("abort_sclk", 32'(bus.sclk), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    ce.delete();
    sb.delete();
    model_rx = 8'h00;
    dc = done_count;
    repeat (3) begin @(negedge clk); #1; end
    chk("abort_rx", 32'(bus.rx_data), 32'd0);
    reset_n = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    chk("no_done_after_abort", done_count, dc);
    issue(0, 0, 1, 1, 8'hFF, 1, 8'h00);
    wait_idle();
    repeat (2) begin @(negedge clk); #1; end

    // back-to-back: second start in the done cycle of the first
    issue(0, 0, 0, 1, 8'hC3, 1, 8'h00);
    wait_until(last_T + last_L);
    issue(1, 0, 0, 0, 8'h81, 0, 8'h7E);
    wait_idle();
    repeat (2) begin @(negedge clk); #1; end

    // slowest divider, H = 256
    issue(2, 0, 1, 255, 8'h69, 0, 8'hB4);
    wait_idle();

    // randomized transfers
    for (int i = 0; i < 24; i++) begin
      int sel, div, gap;
      bit pol, pha, loop;
      logic [7:0] tx, sw;
      sel  = $urandom_range(0, 3);
      pol  = 1'($urandom_range(0, 1));
      pha  = 1'($urandom_range(0, 1));
      div  = $urandom_range(0, 3);
      tx   = 8'($urandom_range(0, 255));
      sw   = 8'($urandom_range(0, 255));
      loop = 1'($urandom_range(0, 1));
      issue(sel, pol, pha, div, tx, loop, sw);
      wait_idle();
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(negedge clk); #1; end
    end
    repeat (6) begin @(negedge clk); #1; end
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
